// File: rtl/simon_round_engine.sv
// Simon 32/64 encryption engine.
// Loads plaintext and key as 4-bit nibbles, runs 32 rounds at one round per
// clock, and shifts the ciphertext out on the same nibble interface.
// The z0 constant comes from an external LFSR stage. This block holds that
// stage in reset whenever it is not running, so the sequence restarts on
// every run.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | after reset; nibbles shift in; a falling i_shift starts a run
// ST_RUN  | one round plus one key step per edge, 32 edges; i_shift ignored
// ST_DONE | ciphertext on o_data; shifting reloads; a falling i_shift reruns

module simon_round_engine (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_shift,
   input  logic [3:0] i_data,
   input  logic       i_z,
   output logic       o_z_rst,
   output logic [3:0] o_data,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [95:0] r_q, r_d;
   logic [4:0]  rnd_q, rnd_d;
   logic        shift_dly_q, shift_dly_d;

   logic [15:0] x, y, k3, k2, k1, k0;
   logic [15:0] x_new, k_new, t_a, t_b;

   // Field view of the state register and the round / key-step arithmetic
   always_comb begin
      x  = r_q[95:80];
      y  = r_q[79:64];
      k3 = r_q[63:48];
      k2 = r_q[47:32];
      k1 = r_q[31:16];
      k0 = r_q[15:0];

      x_new = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]})
                ^ {x[13:0], x[15:14]} ^ k0;

      t_a   = {k3[2:0], k3[15:3]} ^ k1;
      t_b   = t_a ^ {t_a[0], t_a[15:1]};
      k_new = ~k0 ^ t_b ^ {15'b0, i_z} ^ 16'h0003;
   end

   // Next-state logic: load shifting, run start on falling i_shift, rounds
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      rnd_d       = rnd_q;
      shift_dly_d = i_shift;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (i_shift) begin
               r_d = {r_q[91:0], i_data};
            end else if (shift_dly_q) begin
               state_d = ST_RUN;
               rnd_d   = 5'd0;
            end
         end
         ST_RUN: begin
            // Key words past round 27 are still generated; nothing reads them.
            r_d   = {x_new, x, k_new, k3, k2, k1};
            rnd_d = rnd_q + 5'd1;
            if (rnd_q == 5'd31) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath and round-counter registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         r_q         <= 96'h0;
         rnd_q       <= 5'd0;
         shift_dly_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         rnd_q       <= rnd_d;
         shift_dly_q <= shift_dly_d;
      end
   end

   // Outputs decoded from state; the LFSR is released only while running
   always_comb begin
      o_z_rst = (state_q != ST_RUN);
      o_busy  = (state_q == ST_RUN);
      o_done  = (state_q == ST_DONE);
      o_data  = (state_q == ST_DONE) ? r_q[95:92] : 4'h0;
   end

endmodule

// File: tb/tb_simon_round_engine.sv
// Testbench for simon_round_engine: a z0 sequencer stands in for the LFSR
// stage, and a word-level Simon 32/64 model supplies expected ciphertexts.

module tb_simon_round_engine;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_shift;
   logic [3:0] i_data;
   logic       i_z;
   logic       o_z_rst;
   logic [3:0] o_data;
   logic       o_busy;
   logic       o_done;

   int tests = 0;
   int fails = 0;

   localparam logic [95:0] STD_BLK = 96'h6565_6877_1918_1110_0908_0100;
   localparam logic [31:0] STD_CT  = 32'hc69b_e9bb;

   logic [0:61] z0_seq = 62'b11111010001001010110000111001101111101000100101011000011100110;
   int          z_idx  = 0;

   simon_round_engine dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_shift (i_shift),
      .i_data  (i_data),
      .i_z     (i_z),
      .o_z_rst (o_z_rst),
      .o_data  (o_data),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // z0 source: restarts while held in reset, advances one bit per edge otherwise
   always @(posedge i_clk) begin
      if (o_z_rst) z_idx <= 0;
      else         z_idx <= (z_idx == 61) ? 0 : z_idx + 1;
   end
   assign i_z = z0_seq[z_idx];

   function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
      return 16'((v << n) | (v >> (16 - n)));
   endfunction

   // Word-level Simon 32/64: expand the full key schedule, then 32 rounds
   function automatic logic [31:0] simon_ref(input logic [95:0] blk);
      logic [15:0] k [0:31];
      logic [15:0] x, y, tmp;
      x    = blk[95:80];
      y    = blk[79:64];
      k[3] = blk[63:48];
      k[2] = blk[47:32];
      k[1] = blk[31:16];
      k[0] = blk[15:0];
      for (int i = 4; i < 32; i++) begin
         tmp  = rol16(k[i-1], 13) ^ k[i-3];
         tmp  = tmp ^ rol16(tmp, 15);
         k[i] = 16'hfffc ^ k[i-4] ^ tmp ^ {15'b0, z0_seq[i-4]};
      end
      for (int i = 0; i < 32; i++) begin
         tmp = x;
         x   = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ k[i];
         y   = tmp;
      end
      return {x, y};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Shift a full 24-nibble block, capturing o_data over the first 8 shifts,
   // then drop i_shift so the next edge starts a run.
   task automatic shift_block(input logic [95:0] blk, output logic [31:0] rd);
      rd = 32'h0;
      for (int i = 0; i < 24; i++) begin
         @(negedge i_clk);
         if (i < 8) rd = {rd[27:0], o_data};
         i_shift = 1'b1;
         i_data  = blk[95-4*i -: 4];
      end
      @(negedge i_clk);
      i_shift = 1'b0;
      i_data  = 4'h0;
   endtask

   // Follow one run to completion with a bounded cycle budget
   task automatic run_block(input bit toggle);
      int         cnt;
      bit         zr_bad, d_bad;
      logic [5:0] zb;
      cnt    = 0;
      zr_bad = 1'b0;
      d_bad  = 1'b0;
      zb     = 6'h0;
      for (int c = 0; c < 100; c++) begin
         @(negedge i_clk);
         if (o_busy) begin
            if (cnt < 6) zb[5-cnt] = i_z;
            if (o_z_rst !== 1'b0) zr_bad = 1'b1;
            if (o_data !== 4'h0 || o_done !== 1'b0) d_bad = 1'b1;
            if (toggle && cnt == 5) i_shift = 1'b1;
            if (toggle && cnt == 7) i_shift = 1'b0;
            cnt++;
         end else if (cnt > 0) begin
            break;
         end
      end
      check("busy_cycles",     32'(cnt),    32'd32);
      check("zrst_low_in_run", 32'(zr_bad), 32'd0);
      check("quiet_in_run",    32'(d_bad),  32'd0);
      check("z_prefix",        32'(zb),     32'b111110);
      check("done_high",       32'(o_done), 32'd1);
      check("busy_low",        32'(o_busy), 32'd0);
      check("zrst_high_done",  32'(o_z_rst), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp_prev;
      logic [95:0] blk;

      i_rst_n = 1'b0;
      i_shift = 1'b0;
      i_data  = 4'h0;
      repeat (3) @(negedge i_clk);
      check("rst_data",  32'(o_data),  32'h0);
      check("rst_busy",  32'(o_busy),  32'h0);
      check("rst_done",  32'(o_done),  32'h0);
      check("rst_zrst",  32'(o_z_rst), 32'h1);
      i_rst_n = 1'b1;

      // Partial load of three nibbles over the reset-cleared register
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         i_shift = 1'b1;
         i_data  = 4'ha + 4'(i);
      end
      @(negedge i_clk);
      i_shift = 1'b0;
      check("idle_data_zero", 32'(o_data), 32'h0);
      run_block(1'b0);
      exp_prev = simon_ref(96'habc);

      // Standard vector, loaded back-to-back while reading the partial result
      shift_block(STD_BLK, rd);
      check("partial_ct", rd, exp_prev);
      run_block(1'b0);
      exp_prev = STD_CT;

      // Random plaintexts and keys, each reload reading out the previous result
      for (int n = 0; n < 4; n++) begin
         blk = {$urandom, $urandom, $urandom};
         shift_block(blk, rd);
         check("chained_ct", rd, exp_prev);
         run_block(1'b0);
         exp_prev = simon_ref(blk);
      end

      // i_shift wiggled during the run must not disturb it
      shift_block(STD_BLK, rd);
      check("random_last_ct", rd, exp_prev);
      run_block(1'b1);

      // Reset in the middle of a run
      shift_block(STD_BLK, rd);
      check("toggle_ct", rd, STD_CT);
      repeat (11) @(negedge i_clk);
      check("busy_before_rst", 32'(o_busy), 32'h1);
      i_rst_n = 1'b0;
      #1;
      check("midrst_data", 32'(o_data),  32'h0);
      check("midrst_busy", 32'(o_busy),  32'h0);
      check("midrst_done", 32'(o_done),  32'h0);
      check("midrst_zrst", 32'(o_z_rst), 32'h1);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      shift_block(STD_BLK, rd);
      check("idle_readout_zero", rd, 32'h0);
      run_block(1'b0);
      shift_block(STD_BLK, rd);
      check("post_rst_ct", rd, STD_CT);
      run_block(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/simon_round_engine.md
# simon_round_engine

Simon 32/64 encryption datapath for the Simon design. It loads a 32-bit plaintext and a 64-bit key as 4-bit nibbles, then runs 32 rounds at one round per clock. It consumes the z0 constant bit stream from the z0 LFSR stage, which it sequences through that stage's reset input, and presents the ciphertext back out on the same nibble interface.

## Interface
- No parameters: fixed to Simon 32/64 (word 16 bits, key 4 words, 32 rounds, z0 sequence).
- i_clk  input  1  clock; all state on posedge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_shift  input  1  high: shift i_data into the state register this cycle (IDLE/DONE only).
- i_data  input  4  load nibble, MSB-first.
- i_z  input  1  current z0 bit from the LFSR stage's output.
- o_z_rst  output  1  drives the LFSR stage's reset; high in every state except RUN.
- o_data  output  4  ciphertext nibble; R[95:92] in DONE, 4'h0 otherwise.
- o_busy  output  1  high in RUN.
- o_done  output  1  high in DONE.

## Operation
- State register R[95:0] = {x[15:0], y[15:0], k3, k2, k1, k0}.
- Shift-in order: x, then y, then k3, k2, k1, k0, each MSB nibble first; 24 nibbles per block.
- Shift operation: R <= {R[91:0], i_data}.
- FSM states: IDLE, RUN, DONE. Round counter rnd[4:0]. Registered shift_d tracks i_shift on every edge, in every state.
- IDLE/DONE:
  - i_shift=1: shift.
  - i_shift=0 with shift_d=1 (falling edge): go RUN, rnd<=0.
  - Otherwise hold.
- RUN: each edge performs one round and one key-schedule step; i_shift is ignored (no shift, no restart).
  - Round: x <= y ^ ((x<<<1) & (x<<<8)) ^ (x<<<2) ^ k0; y <= x.
  - Key step: t = (k3>>>3) ^ k1; t = t ^ (t>>>1); knew = ~k0 ^ t ^ {15'b0, i_z} ^ 16'h0003. Then k0<=k1, k1<=k2, k2<=k3, k3<=knew.
  - All arithmetic is 16-bit; rotates wrap within the word.
  - Key steps after round 27 are computed but unused; no special casing.
- rnd==31 at an edge: perform the last round, go DONE.
- DONE: o_data = x[15:12]. Each shift cycle exposes the next ciphertext nibble while new data enters. State stays DONE until a falling edge starts a new RUN.
- A partial reload (fewer than 24 nibbles) is legal. The run uses whatever R holds; this is not an error.
- Reset (any time, including mid-RUN): state=IDLE, R=0, rnd=0, shift_d=0, o_data=0, o_busy=0, o_done=0, o_z_rst=1.

## Timing
- o_z_rst is decoded combinationally from state. It is high on the edge that enters RUN, so the LFSR reloads 5'b00001 there.
- i_z is therefore z0[r] during RUN cycle r (r = 0..31); z0[0]=1.
- Round r consumes z0[r] in the same cycle. The LFSR advances on each RUN edge.
- Latency: E0 is the first edge sampling i_shift=0 after shifting. RUN occupies cycles after E0 through E32. o_done rises after E32 (32 cycles). o_busy is high for exactly 32 cycles.
- o_data is valid the cycle o_done rises. It advances one nibble per edge with i_shift=1.
- Back-to-back operation: a reload in DONE followed by a falling edge restarts with no idle gap.

## Test plan
- Reset, no stimulus -> o_data=0, o_busy=0, o_done=0, o_z_rst=1; shifting then releasing i_shift leaves o_data=0 until DONE.
- Standard vector: shift 6,5,6,5,6,8,7,7,1,9,1,8,1,1,1,0,0,9,0,8,0,1,0,0 then drop i_shift:
  - o_busy high 32 cycles, o_z_rst low for the same 32 cycles, then o_done=1.
  - Eight shift cycles read o_data = c,6,9,b,e,9,b,b (ciphertext c69b e9bb).
- i_shift toggled (high then low) during RUN -> ignored; done timing and ciphertext are identical to the standard vector.
- i_rst_n pulsed low at RUN round 10 -> immediate IDLE with all outputs at reset values. A full reload of the standard vector then yields c69b e9bb.
- Back-to-back: in DONE, shift 24 nibbles of the standard vector (reading c69be9bb out on the first 8), drop i_shift -> second run is identical, o_done again after 32 cycles.
- z alignment: monitor i_z during RUN cycles 0..4 -> 1,1,1,1,1; cycle 5 -> 0 (z0 prefix 111110).
